// File: rtl/reg_file_pkg.sv
// Shared types and the byte-lane merge used by both the write path and the read bypass.
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Widest word the merge helper handles; callers cast their WIDTH in and out.
  localparam int MAX_W = 128;
  localparam int MAX_B = MAX_W / 8;

  // Enabled byte lanes come from new_w, all others keep old_w.
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_B-1:0] be);
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_B; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: range check, write bypass and output registers.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              en,        // already gated to IDLE by the top
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  mem_word,  // storage at addr (0 when out of range)
  input  logic              wr_acc,    // write accepted this cycle
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_word,   // merged value being written
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              oor        // this port requested an out-of-range address
);

  logic             in_range;
  logic             hit;
  logic [WIDTH-1:0] rd_nxt;

  assign in_range = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
  assign hit      = wr_acc && (wr_addr == addr);
  assign oor      = en && !in_range;

  // Pick the value to capture: bypassed write, stored word, or 0 when out of range.
  always_comb begin
    rd_nxt = '0;
    if (in_range) rd_nxt = hit ? wr_word : mem_word;
  end

  // Data holds when idle; valid is a one-cycle pulse per request.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= en;
      if (en) rd_data <= rd_nxt;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read one-write register file with byte enables, bypass, range error and clear-all.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WrEn,
  input  logic [ADDR_W-1:0]  WrAddr,
  input  logic [WIDTH-1:0]   WrData,
  input  logic [WIDTH/8-1:0] WrByteEn,
  input  logic               RdEnA,
  input  logic [ADDR_W-1:0]  RdAddrA,
  output logic [WIDTH-1:0]   RdDataA,
  output logic               RdValidA,
  input  logic               RdEnB,
  input  logic [ADDR_W-1:0]  RdAddrB,
  output logic [WIDTH-1:0]   RdDataB,
  output logic               RdValidB,
  input  logic               ClrReq,
  output logic               Busy,
  output logic               AddrErr
);

  logic [WIDTH-1:0]  mem [DEPTH];
  state_e            state, state_nxt;
  logic [ADDR_W-1:0] clr_idx, clr_idx_nxt;
  logic              idle, wr_in_range, wr_acc, oor_a, oor_b;
  logic [WIDTH-1:0]  wr_old, wr_merged, word_a, word_b;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
  endfunction

  assign idle        = (state == IDLE);
  assign wr_in_range = in_range(WrAddr);
  assign wr_acc      = idle && WrEn && wr_in_range;
  assign wr_old      = wr_in_range ? mem[WrAddr] : '0;
  assign wr_merged   = WIDTH'(byte_merge(MAX_W'(wr_old), MAX_W'(WrData), MAX_B'(WrByteEn)));
  assign word_a      = in_range(RdAddrA) ? mem[RdAddrA] : '0;
  assign word_b      = in_range(RdAddrB) ? mem[RdAddrB] : '0;

  // Clear sequencer: walk clr_idx 0..DEPTH-1 then drop back to IDLE.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      IDLE: if (ClrReq) begin
        state_nxt   = CLEAR;
        clr_idx_nxt = '0;
      end
      CLEAR: if (clr_idx == ADDR_W'(DEPTH - 1)) begin
        state_nxt   = IDLE;
        clr_idx_nxt = '0;
      end else begin
        clr_idx_nxt = clr_idx + ADDR_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state plus the registered status outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      clr_idx <= '0;
      Busy    <= 1'b0;
      AddrErr <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      Busy    <= (state_nxt == CLEAR);
      AddrErr <= idle && ((WrEn && !wr_in_range) || oor_a || oor_b);
    end
  end

  // Storage: clear has priority; writes only land while IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (wr_acc) begin
      mem[WrAddr] <= wr_merged;
    end
  end

  reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_a (
    .gclk(CLK), .grst_n(RST), .en(idle && RdEnA), .addr(RdAddrA), .mem_word(word_a),
    .wr_acc(wr_acc), .wr_addr(WrAddr), .wr_word(wr_merged),
    .rd_data(RdDataA), .rd_valid(RdValidA), .oor(oor_a)
  );

  reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_b (
    .gclk(CLK), .grst_n(RST), .en(idle && RdEnB), .addr(RdAddrB), .mem_word(word_b),
    .wr_acc(wr_acc), .wr_addr(WrAddr), .wr_word(wr_merged),
    .rd_data(RdDataB), .rd_valid(RdValidB), .oor(oor_b)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: 8-entry instance scoreboarded, 6-entry instance for range errors.
module tb_reg_file_2r1w;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wr_en = 1'b0, rd_en_a = 1'b0, rd_en_b = 1'b0, clr = 1'b0;
  logic [2:0]  wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic [15:0] rd_data_a, rd_data_b, rd_data_a6, rd_data_b6;
  logic        rd_valid_a, rd_valid_b, busy, addr_err;
  logic        rd_valid_a6, rd_valid_b6, busy6, addr_err6;

  int          checks = 0, errors = 0;
  logic [15:0] mdl [8];
  logic [15:0] qa[$], qb[$];
  logic [15:0] ea, eb;

  always #5 clk = ~clk;

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) dut (
    .CLK(clk), .RST(rst_n), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrByteEn(wr_be),
    .RdEnA(rd_en_a), .RdAddrA(rd_addr_a), .RdDataA(rd_data_a), .RdValidA(rd_valid_a),
    .RdEnB(rd_en_b), .RdAddrB(rd_addr_b), .RdDataB(rd_data_b), .RdValidB(rd_valid_b),
    .ClrReq(clr), .Busy(busy), .AddrErr(addr_err)
  );

  reg_file_2r1w #(.WIDTH(16), .DEPTH(6), .ADDR_W(3)) dut6 (
    .CLK(clk), .RST(rst_n), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrByteEn(wr_be),
    .RdEnA(rd_en_a), .RdAddrA(rd_addr_a), .RdDataA(rd_data_a6), .RdValidA(rd_valid_a6),
    .RdEnB(rd_en_b), .RdAddrB(rd_addr_b), .RdDataB(rd_data_b6), .RdValidB(rd_valid_b6),
    .ClrReq(clr), .Busy(busy6), .AddrErr(addr_err6)
  );

  function automatic logic [15:0] mrg(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
    return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
  endfunction

  // Scoreboard: every valid pulse of the 8-entry instance pops one expected word.
  always @(negedge clk) if (rst_n) begin
    if (rd_valid_a) begin
      checks++;
      if (qa.size() == 0) begin
        errors++; $display("FAIL rd_a_unexpected_valid got %h", rd_data_a);
      end else begin
        ea = qa.pop_front();
        if (rd_data_a !== ea) begin errors++; $display("FAIL rd_a_data got %h exp %h", rd_data_a, ea); end
      end
    end
    if (rd_valid_b) begin
      checks++;
      if (qb.size() == 0) begin
        errors++; $display("FAIL rd_b_unexpected_valid got %h", rd_data_b);
      end else begin
        eb = qb.pop_front();
        if (rd_data_b !== eb) begin errors++; $display("FAIL rd_b_data got %h exp %h", rd_data_b, eb); end
      end
    end
  end

  // One IDLE-state cycle: drive, update model, push expected reads, wait to next negedge.
  task automatic op(input logic we, input logic [2:0] wa, input logic [15:0] wd, input logic [1:0] be,
                    input logic rea, input logic [2:0] aa, input logic reb, input logic [2:0] ab);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en_a = rea; rd_addr_a = aa; rd_en_b = reb; rd_addr_b = ab; clr = 1'b0;
    if (we) mdl[wa] = mrg(mdl[wa], wd, be);
    if (rea) qa.push_back(mdl[aa]);
    if (reb) qb.push_back(mdl[ab]);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    idle();
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++; $display("FAIL %s_missing_valid got %0d/%0d pending exp 0/0", name, qa.size(), qb.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, busy, addr_err} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h %h %b%b%b%b exp 0", rd_data_a, rd_data_b,
                         rd_valid_a, rd_valid_b, busy, addr_err);
    end
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) op(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(i), 1'b1, 3'(7 - i));
    drain("reset_read");
  endtask

  task automatic test_byte_en();
    op(1'b1, 3'd3, 16'hABCD, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0);
    op(1'b1, 3'd3, 16'h1200, 2'b10, 1'b0, 3'd0, 1'b0, 3'd0);
    op(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd3, 1'b0, 3'd0);
    checks++;
    if (rd_data_a !== 16'h12CD) begin errors++; $display("FAIL byte_en_merge got %h exp 12cd", rd_data_a); end
    op(1'b1, 3'd3, 16'hFFFF, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0);
    op(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd3, 1'b0, 3'd0);
    checks++;
    if (rd_data_a !== 16'h12CD) begin errors++; $display("FAIL byte_en_none got %h exp 12cd", rd_data_a); end
    drain("byte_en");
  endtask

  task automatic test_bypass();
    op(1'b1, 3'd5, 16'h5A5A, 2'b11, 1'b1, 3'd5, 1'b1, 3'd5);
    checks++;
    if (rd_data_a !== 16'h5A5A || rd_data_b !== 16'h5A5A) begin
      errors++; $display("FAIL bypass_full got %h/%h exp 5a5a/5a5a", rd_data_a, rd_data_b);
    end
    op(1'b1, 3'd3, 16'hFF00, 2'b01, 1'b1, 3'd3, 1'b0, 3'd0);
    checks++;
    if (rd_data_a !== 16'h1200) begin errors++; $display("FAIL bypass_partial got %h exp 1200", rd_data_a); end
    drain("bypass");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      op(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)),
         1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      checks++;
      if (addr_err !== 1'b0) begin errors++; $display("FAIL b2b_addr_err got %b exp 0", addr_err); end
    end
    drain("back_to_back");
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < 8; i++) op(1'b1, 3'(i), 16'hFFFF, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0);
    op(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd6, 1'b0, 3'd0);
    wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; rd_en_a = 1'b1; rd_addr_a = 3'd2; rd_en_b = 1'b1; rd_addr_b = 3'd7;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      checks++;
      if (rd_valid_a || rd_valid_b || addr_err) begin
        errors++; $display("FAIL clear_ignore got valid %b%b err %b exp 000", rd_valid_a, rd_valid_b, addr_err);
      end
      @(negedge clk);
    end
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    checks++;
    if (n != 8) begin errors++; $display("FAIL clear_busy_len got %0d exp 8", n); end
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(i), 1'b1, 3'(i));
      checks++;
      if (rd_data_a !== 16'h0) begin errors++; $display("FAIL clear_readback got %h exp 0000", rd_data_a); end
    end
    drain("clear");
  endtask

  task automatic test_reset_mid();
    op(1'b1, 3'd1, 16'h1234, 2'b11, 1'b1, 3'd1, 1'b0, 3'd0);
    idle();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; rd_en_a = 1'b1; rd_addr_a = 3'd1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rd_data_a !== 16'h1234) begin
      errors++; $display("FAIL pre_reset_state got busy %b data %h exp 1 1234", busy, rd_data_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, busy, addr_err} !== '0) begin
      errors++; $display("FAIL async_reset got %h %h %b%b%b%b exp 0", rd_data_a, rd_data_b,
                         rd_valid_a, rd_valid_b, busy, addr_err);
    end
    @(negedge clk);
    rst_n = 1'b1; rd_en_a = 1'b0;
    qa.delete(); qb.delete();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    op(1'b1, 3'd2, 16'h7777, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0);
    op(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd2, 1'b1, 3'd1);
    checks++;
    if (rd_data_a !== 16'h7777 || rd_data_b !== 16'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset got %h %h busy %b exp 7777 0000 0", rd_data_a, rd_data_b, busy);
    end
    drain("reset_mid");
  endtask

  task automatic test_out_of_range();
    logic [15:0] ev;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    qa.delete(); qb.delete();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    for (int i = 0; i < 6; i++) op(1'b1, 3'(i), 16'(16'h1111 * (i + 1)), 2'b11, 1'b0, 3'd0, 1'b0, 3'd0);
    op(1'b1, 3'd7, 16'hFFFF, 2'b11, 1'b1, 3'd6, 1'b0, 3'd0);
    checks++;
    if (rd_data_a6 !== 16'h0 || rd_valid_a6 !== 1'b1 || addr_err6 !== 1'b1) begin
      errors++; $display("FAIL oor_read got %h v%b err%b exp 0000 v1 err1", rd_data_a6, rd_valid_a6, addr_err6);
    end
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL oor_depth8_err got %b exp 0", addr_err); end
    idle();
    checks++;
    if (addr_err6 !== 1'b0 || rd_valid_a6 !== 1'b0) begin
      errors++; $display("FAIL oor_pulse_len got err%b v%b exp 0 0", addr_err6, rd_valid_a6);
    end
    for (int i = 0; i < 6; i++) begin
      op(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b1, 3'(i));
      ev = 16'(16'h1111 * (i + 1));
      checks++;
      if (rd_data_b6 !== ev || addr_err6 !== 1'b0) begin
        errors++; $display("FAIL oor_storage got %h err%b exp %h err0", rd_data_b6, addr_err6, ev);
      end
    end
    drain("oor");
  endtask

  initial begin
    test_reset();
    test_byte_en();
    test_bypass();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Parametrised register file with two independent registered read ports and one byte-enabled write port. It succeeds the single-port 8x16 register file.
- Read and write are allowed in the same cycle, with write-to-read bypass.
- An out-of-range address error flag is provided.
- A sequenced clear-all operation is provided.
- Sits between the control FSM / bus slave and datapath blocks that need concurrent operand fetch.

Parameters:
WIDTH, 16, data width in bits; must be a multiple of 8
DEPTH, 8, number of entries; need not be a power of 2
ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
WrEn  input  1  write request
WrAddr  input  ADDR_W  write address
WrData  input  WIDTH  write data
WrByteEn  input  WIDTH/8  per-byte write enable; bit i covers WrData[8i+7:8i]
RdEnA  input  1  port A read request
RdAddrA  input  ADDR_W  port A address
RdDataA  output  WIDTH  port A read data, registered
RdValidA  output  1  port A data valid pulse
RdEnB  input  1  port B read request
RdAddrB  input  ADDR_W  port B address
RdDataB  output  WIDTH  port B read data, registered
RdValidB  output  1  port B data valid pulse
ClrReq  input  1  request to clear all entries
Busy  output  1  clear sequence in progress
AddrErr  output  1  one-cycle pulse on any out-of-range access

Behaviour:
- Reset (RST low, asynchronous):
  - All entries go to 0.
  - RdDataA, RdDataB, RdValidA, RdValidB, Busy and AddrErr go to 0.
  - FSM goes to IDLE and the clear counter goes to 0.
  - Reset asserted mid-clear aborts the clear; everything reads 0 afterwards regardless.
- Write (IDLE only):
  - On a rising edge with WrEn=1 and WrAddr<DEPTH, each byte lane i with WrByteEn[i]=1 takes WrData lane i.
  - Other lanes hold.
  - WrByteEn=0 means no change.
- Read (IDLE only), 1-cycle latency:
  - On the edge where RdEnX=1, RdDataX <= entry[RdAddrX] and RdValidX <= 1.
  - When RdEnX=0: RdValidX <= 0 and RdDataX holds its last value.
- Read during write:
  - Reading and writing in the same cycle is legal.
  - If RdAddrX==WrAddr and the write is accepted, RdDataX returns the merged new value: enabled lanes from WrData, other lanes from the old entry.
  - Both ports may read the same address simultaneously.
- Out of range (address >= DEPTH):
  - A write is dropped.
  - A read returns RdDataX=0 with RdValidX=1.
  - AddrErr=1 for exactly the next cycle, asserted if any accepted port is out of range.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on ClrReq=1. Busy=1 from the next cycle.
  - In CLEAR, one entry is zeroed per cycle in order 0..DEPTH-1 via counter clr_idx. Counter width is ADDR_W; no wrap past DEPTH-1.
  - After entry DEPTH-1 is zeroed, the FSM returns to IDLE. Busy is high for exactly DEPTH cycles.
  - While in CLEAR, WrEn/RdEnA/RdEnB are ignored: no writes, RdValid stays 0, no AddrErr.
  - ClrReq during CLEAR is ignored; a ClrReq held high retriggers one cycle after returning to IDLE.
  - A write coinciding with the ClrReq cycle in IDLE is accepted first; the clear then zeroes that entry.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Package reg_file_pkg:
  - state enum {IDLE, CLEAR}
  - function byte_merge(old, new, be) returning the lane-merged word, shared by the write path and the bypass path
- One natural sub-module: reg_file_rd_port, instantiated twice. It contains:
  - the address range check
  - the bypass compare
  - the output registers for RdData/RdValid
- Storage, write logic and the clear FSM stay in the top module.

Test Plan:
- Reset then read all 8 addresses on both ports -> RdData=0x0000 each, RdValid pulses 1 cycle after each RdEn.
- Write 0xABCD to addr 3 with WrByteEn=2'b11, then write 0x1200 with WrByteEn=2'b10 -> port A read of addr 3 = 0x12CD.
- Same-cycle write 0x5A5A to addr 5 (byte enables 11) with port A and port B both reading addr 5 -> both RdData=0x5A5A next cycle (bypass).
- Parameters DEPTH=6, ADDR_W=3; write addr 7, read addr 6 -> no storage change, RdDataA=0, RdValidA=1, AddrErr=1 for one cycle.
- Fill all entries with 0xFFFF, pulse ClrReq -> Busy high exactly 8 cycles, RdEn during Busy yields no RdValid, after Busy all reads = 0x0000.
- Assert RST low mid-clear (cycle 3) and mid-read -> all outputs 0 immediately (asynchronous), FSM IDLE after release, writes accepted on the next edge.
